window_buffer_kxk: RTL and testbench

Parametrised K×K sliding-window former for the image pipeline. It takes one K-pixel vertical column per accepted beat from the upstream line buffers and shifts it into a K×K register window. It tracks column and row position and emits a full window only when every tap holds real pixels from the current frame, so windows never straddle a row boundary. Output is registered, uses valid/ready backpressure, and feeds the K×K filter kernels (median, Sobel, Gaussian).

---
 rtl/window_buffer_kxk.sv | 90 +++++++++
 tb/tb_window_buffer_kxk.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_buffer_kxk.sv
// window_buffer_kxk: K x K sliding-window former fed one column per beat, with
// row/column tracking and a registered valid/ready window output.
module window_buffer_kxk #(
  parameter int DATA_W = 8,
  parameter int K = 3,
  parameter int CNT_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic [CNT_W-1:0]        img_w_i,
  input  logic [CNT_W-1:0]        img_h_i,
  input  logic [K*DATA_W-1:0]     col_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [K*K*DATA_W-1:0]   window_o,
  output logic [CNT_W-1:0]        x_o,
  output logic [CNT_W-1:0]        y_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    eol_o,
  output logic                    eof_o
);
  localparam logic [CNT_W-1:0] KM1 = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((K - 1) / 2);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [CNT_W-1:0] c, r, w_l, h_l, w_eff, h_eff;
  logic [K*K*DATA_W-1:0] win, win_nxt;
  logic acc, first, emit, eol, last_row;
  assign ready_o = (!valid_o || ready_i) && !clear_i;
  assign acc = valid_i && ready_o;
  // Dimensions take effect on the first beat of a frame, so use the live inputs there.
  assign first = (c == '0) && (r == '0);
  assign w_eff = first ? img_w_i : w_l;
  assign h_eff = first ? img_h_i : h_l;
  assign eol = c == w_eff - ONE;
  assign last_row = r == h_eff - ONE;
  assign emit = acc && (c >= KM1) && (r >= KM1);
  assign window_o = win;
  always_comb begin
    win_nxt = win;
    for (int j = 0; j < K; j++) begin
      for (int k = 0; k < K - 1; k++)
        win_nxt[(j*K+k)*DATA_W +: DATA_W] = win[(j*K+k+1)*DATA_W +: DATA_W];
      win_nxt[(j*K+K-1)*DATA_W +: DATA_W] = col_i[j*DATA_W +: DATA_W];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= '0;
      r <= '0;
      w_l <= '0;
      h_l <= '0;
      win <= '0;
      valid_o <= 1'b0;
      eol_o <= 1'b0;
      eof_o <= 1'b0;
      x_o <= '0;
      y_o <= '0;
    end else if (clear_i) begin
      c <= '0;
      r <= '0;
      w_l <= img_w_i;
      h_l <= img_h_i;
      win <= '0;
      valid_o <= 1'b0;
      eol_o <= 1'b0;
      eof_o <= 1'b0;
      x_o <= '0;
      y_o <= '0;
    end else begin
      if (acc) begin
        win <= win_nxt;
        w_l <= w_eff;
        h_l <= h_eff;
        c <= eol ? '0 : c + ONE;
        r <= eol ? (last_row ? '0 : r + ONE) : r;
      end
      if (emit) begin
        valid_o <= 1'b1;
        x_o <= c - HALF;
        y_o <= r - HALF;
        eol_o <= eol;
        eof_o <= eol && last_row;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_window_buffer_kxk.sv
// tb_window_buffer_kxk: random and ramp stimulus against a column-history model of the window former.
module tb_window_buffer_kxk;
  localparam int DW = 8, K = 3, CW = 10;
  logic clk = 1'b0, rst = 1'b1, clear_i = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
  logic [CW-1:0] img_w = 10'd5, img_h = 10'd4;
  logic [K*DW-1:0] col_i = '0;
  logic ready_o, valid_o, eol_o, eof_o;
  logic [K*K*DW-1:0] window_o;
  logic [CW-1:0] x_o, y_o;
  logic clear5 = 1'b0, valid5 = 1'b0, ready5_i = 1'b1;
  logic [CW-1:0] img6 = 10'd6;
  logic [5*DW-1:0] col5 = '0;
  logic ready5_o, v5, eol5, eof5;
  logic [25*DW-1:0] win5;
  logic [CW-1:0] x5, y5;

  window_buffer_kxk #(.DATA_W(DW), .K(K), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .img_w_i(img_w), .img_h_i(img_h),
    .col_i(col_i), .valid_i(valid_i), .ready_o(ready_o), .window_o(window_o),
    .x_o(x_o), .y_o(y_o), .valid_o(valid_o), .ready_i(ready_i), .eol_o(eol_o), .eof_o(eof_o));

  window_buffer_kxk #(.DATA_W(DW), .K(5), .CNT_W(CW)) dut5 (
    .clk(clk), .rst(rst), .clear_i(clear5), .img_w_i(img6), .img_h_i(img6),
    .col_i(col5), .valid_i(valid5), .ready_o(ready5_o), .window_o(win5),
    .x_o(x5), .y_o(y5), .valid_o(v5), .ready_i(ready5_i), .eol_o(eol5), .eof_o(eof5));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: the window is simply the last K accepted columns; position comes from the beat index in the frame.
  logic [K*DW-1:0] hist [K];
  logic [K*K*DW-1:0] mwin;
  logic mv, meol, meof, ma;
  int mn, mw, mh, mx, my, mc, mr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mn = 0; mw = 0; mh = 0; mv = 0; meol = 0; meof = 0; mx = 0; my = 0; mwin = '0;
      for (int i = 0; i < K; i++) hist[i] = '0;
    end else if (clear_i) begin
      mn = 0; mv = 0; meol = 0; meof = 0; mw = int'(img_w); mh = int'(img_h);
      for (int i = 0; i < K; i++) hist[i] = '0;
    end else begin
      ma = valid_i && (!mv || ready_i);
      if (ma) begin
        if (mn == 0) begin mw = int'(img_w); mh = int'(img_h); end
        mc = mn % mw;
        mr = mn / mw;
        for (int i = 0; i < K - 1; i++) hist[i] = hist[i+1];
        hist[K-1] = col_i;
        mn = (mn + 1) % (mw * mh);
      end
      if (ma && mc >= K - 1 && mr >= K - 1) begin
        mv = 1;
        for (int j = 0; j < K; j++)
          for (int k = 0; k < K; k++) mwin[(j*K+k)*DW +: DW] = hist[k][j*DW +: DW];
        mx = mc - (K - 1) / 2;
        my = mr - (K - 1) / 2;
        meol = (mc == mw - 1);
        meof = meol && (mr == mh - 1);
      end else if (ready_i) mv = 0;
    end
  end

  typedef struct {
    logic [K*K*DW-1:0] w;
    int x, y;
    logic eol, eof;
  } rec_t;
  rec_t got[$];
  rec_t q5[$];
  typedef struct {
    logic [25*DW-1:0] w;
    int x, y;
    logic eof;
  } rec5_t;
  rec5_t g5[$];

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_o", 256'(ready_o), 256'((!mv || ready_i) && !clear_i));
      chk("valid_o", 256'(valid_o), 256'(mv));
      if (mv) begin
        chk("window_o", 256'(window_o), 256'(mwin));
        chk("x_o", 256'(x_o), 256'(mx));
        chk("y_o", 256'(y_o), 256'(my));
        chk("eol_o", 256'(eol_o), 256'(meol));
        chk("eof_o", 256'(eof_o), 256'(meof));
      end
      if (valid_o && ready_i) got.push_back('{window_o, int'(x_o), int'(y_o), eol_o, eof_o});
      if (v5) g5.push_back('{win5, int'(x5), int'(y5), eof5});
    end
  end

  function automatic logic [K*K*DW-1:0] lit(input int a[9]);
    logic [K*K*DW-1:0] v;
    for (int i = 0; i < 9; i++) v[i*DW +: DW] = DW'(a[i]);
    return v;
  endfunction

  function automatic logic [K*K*DW-1:0] rwin(input int x, input int y);
    logic [K*K*DW-1:0] v;
    for (int j = 0; j < K; j++)
      for (int k = 0; k < K; k++) v[(j*K+k)*DW +: DW] = DW'((y - 1 + j) * 5 + (x - 1 + k));
    return v;
  endfunction

  function automatic logic [K*DW-1:0] rcol(input int n);
    logic [K*DW-1:0] v;
    for (int j = 0; j < K; j++) v[j*DW +: DW] = DW'((n / 5 - 2 + j) * 5 + n % 5);
    return v;
  endfunction

  function automatic logic [5*DW-1:0] rcol5(input int n);
    logic [5*DW-1:0] v;
    for (int j = 0; j < 5; j++) v[j*DW +: DW] = DW'((n / 6 - 4 + j) * 6 + n % 6);
    return v;
  endfunction

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send(input logic [K*DW-1:0] col, input bit rr);
    int b = 0;
    logic ok;
    valid_i = 1'b1;
    col_i = col;
    do begin
      if (rr) ready_i = 1'($urandom);
      #6 ok = ready_o;
      @(posedge clk); #2;
      b++;
    end while (!ok && b < 100);
    if (!ok) chk("accept timeout", 256'(ok), 256'(1));
    valid_i = 1'b0;
  endtask

  task automatic frame(input bit bub, input bit stall);
    for (int n = 0; n < 20; n++) begin
      if (bub) while ($urandom % 2 == 1) idle(1);
      if (stall && n == 13) begin
        ready_i = 1'b0;
        valid_i = 1'b1;
        col_i = rcol(13);
        repeat (3) begin
          #6;
          chk("stall ready_o", 256'(ready_o), 256'(0));
          chk("stall valid_o", 256'(valid_o), 256'(1));
          chk("stall window", 256'(window_o), 256'(lit('{0, 1, 2, 5, 6, 7, 10, 11, 12})));
          @(posedge clk); #2;
        end
        ready_i = 1'b1;
      end
      send(rcol(n), 1'b0);
    end
    idle(2);
  endtask

  task automatic chkseq(input string nm);
    int x, y;
    chk({nm, " count"}, 256'(got.size()), 256'(6));
    foreach (got[i]) if (i < 6) begin
      x = 1 + i % 3;
      y = 1 + i / 3;
      chk({nm, " win"}, 256'(got[i].w), 256'(rwin(x, y)));
      chk({nm, " x"}, 256'(got[i].x), 256'(x));
      chk({nm, " y"}, 256'(got[i].y), 256'(y));
      chk({nm, " eol"}, 256'(got[i].eol), 256'(x == 3));
      chk({nm, " eof"}, 256'(got[i].eof), 256'(x == 3 && y == 2));
    end
  endtask

  initial begin
    #7;
    chk("rst valid_o", 256'(valid_o), 256'(0));
    chk("rst ready_o", 256'(ready_o), 256'(1));
    chk("rst window", 256'(window_o), 256'(0));
    chk("rst xy", 256'({x_o, y_o, eol_o, eof_o}), 256'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    got.delete();
    frame(1'b0, 1'b0);
    chk("ramp n", 256'(got.size()), 256'(6));
    if (got.size() == 6) begin
      chk("ramp first", 256'(got[0].w), 256'(lit('{0, 1, 2, 5, 6, 7, 10, 11, 12})));
      chk("ramp first xy", 256'({got[0].x, got[0].y}), 256'({32'd1, 32'd1}));
      chk("row3 first", 256'(got[3].w), 256'(lit('{5, 6, 7, 10, 11, 12, 15, 16, 17})));
      chk("ramp last", 256'(got[5].w), 256'(lit('{7, 8, 9, 12, 13, 14, 17, 18, 19})));
      chk("ramp last eol/eof", 256'({got[5].eol, got[5].eof}), 256'(2'b11));
    end
    chkseq("ramp");
    got.delete();
    frame(1'b0, 1'b1);
    chkseq("stall");
    got.delete();
    frame(1'b1, 1'b0);
    chkseq("bubble");
    for (int n = 0; n < 14; n++) send(rcol(n), 1'b0);
    clear_i = 1'b1;
    valid_i = 1'b1;
    col_i = rcol(14);
    @(posedge clk); #3;
    chk("clear valid_o", 256'(valid_o), 256'(0));
    clear_i = 1'b0;
    valid_i = 1'b0;
    got.delete();
    frame(1'b0, 1'b0);
    chkseq("after clear");
    for (int n = 0; n < 14; n++) send(rcol(n), 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst valid_o", 256'(valid_o), 256'(0));
    chk("arst ready_o", 256'(ready_o), 256'(1));
    chk("arst window", 256'(window_o), 256'(0));
    chk("arst xy", 256'({x_o, y_o, eol_o, eof_o}), 256'(0));
    #1 rst = 1'b0;
    @(posedge clk); #2;
    got.delete();
    frame(1'b0, 1'b0);
    chkseq("after rst");
    for (int i = 0; i < 400; i++) begin
      img_w = CW'($urandom_range(3, 7));
      img_h = CW'($urandom_range(3, 7));
      if ($urandom % 50 == 0) begin
        clear_i = 1'b1;
        valid_i = 1'($urandom);
        @(posedge clk); #2;
        clear_i = 1'b0;
      end
      if ($urandom % 2 == 0) idle(1);
      send((K*DW)'($urandom), 1'b1);
    end
    ready_i = 1'b1;
    idle(3);
    g5.delete();
    for (int n = 0; n < 36; n++) begin
      valid5 = 1'b1;
      col5 = rcol5(n);
      @(posedge clk); #2;
    end
    valid5 = 1'b0;
    idle(3);
    chk("k5 count", 256'(g5.size()), 256'(4));
    if (g5.size() == 4) begin
      chk("k5 xy", 256'({g5[0].x, g5[0].y}), 256'({32'd2, 32'd2}));
      chk("k5 top-left", 256'(g5[0].w[0 +: DW]), 256'(0));
      chk("k5 bottom-right", 256'(g5[0].w[24*DW +: DW]), 256'(28));
      chk("k5 eof", 256'(g5[3].eof), 256'(1));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
